// File: rtl/ledr_channel_rx.sv
// LEDR channel receiver: synchronizes d/r rails, detects phase toggles, decodes tokens into an output FIFO.
// Optional feature macro LEDR_RX_ACK_EN: adds ledr_ack and stalls capture on a full FIFO instead of dropping.
module ledr_channel_rx #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SKEW_MAX    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ledr_d,
  input  logic [WIDTH-1:0] ledr_r,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             skew_err,
  input  logic             err_clr
`ifdef LEDR_RX_ACK_EN
  ,
  output logic             ledr_ack
`endif
);

  localparam int unsigned CNT_MAX = (SETTLE > SKEW_MAX) ? SETTLE : SKEW_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SKEW    = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_RESYNC  = 3'd4;

  logic [WIDTH-1:0] d_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] r_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] d_s, ph;
  logic             all_new, none_new, all_same;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p_q, p_d;
  logic             push_q, push_d;
  logic [WIDTH-1:0] push_data_q, push_data_d;
  logic             skew_set;

  logic [WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              overflow_q, overflow_d, skew_err_q, skew_err_d;
  logic              pop, full, wr_en, drop;

  // Per-rail synchronizer chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        d_sync_q[s] <= '0;
        r_sync_q[s] <= '0;
      end
    end else begin
      d_sync_q[0] <= ledr_d;
      r_sync_q[0] <= ledr_r;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        d_sync_q[s] <= d_sync_q[s-1];
        r_sync_q[s] <= r_sync_q[s-1];
      end
    end
  end

  assign d_s      = d_sync_q[SYNC_STAGES-1];
  assign ph       = d_s ^ r_sync_q[SYNC_STAGES-1];
  assign all_new  = (ph == {WIDTH{~p_q}});
  assign none_new = (ph == {WIDTH{p_q}});
  assign all_same = (ph == '0) || (ph == '1);

  assign pop  = out_valid_q & out_ready;
  assign full = (fill_q == FILL_W'(FIFO_DEPTH));

  // Token detection FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    skew_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (all_new) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(1);
        end else if (!none_new) begin
          state_d = ST_SKEW;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_SKEW: begin
        if (all_new) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(1);
        end else if (none_new) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(SKEW_MAX)) begin
          skew_set = 1'b1;
          state_d  = ST_RESYNC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!all_new) begin
          state_d = ST_SKEW;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(SETTLE)) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
`ifdef LEDR_RX_ACK_EN
        if (!full || pop) begin
          push_d      = 1'b1;
          push_data_d = d_s;
          p_d         = ~p_q;
          state_d     = ST_IDLE;
        end
`else
        push_d      = 1'b1;
        push_data_d = d_s;
        p_d         = ~p_q;
        state_d     = ST_IDLE;
`endif
      end
      ST_RESYNC: begin
        if (all_same) begin
          p_d     = ph[0];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO and sticky error next-state; push is applied one cycle after CAPTURE
  always_comb begin
    wr_en = push_q & (~full | pop);
`ifdef LEDR_RX_ACK_EN
    drop  = 1'b0;
`else
    drop  = push_q & full & ~pop;
`endif
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    fill_d      = fill_q + FILL_W'(wr_en) - FILL_W'(pop);
    out_valid_d = (fill_d != '0);
    out_data_d  = '0;
    if (out_valid_d) begin
      if (wr_en && (rd_ptr_d == wr_ptr_q)) out_data_d = push_data_q;
      else                                 out_data_d = mem_q[rd_ptr_d];
    end
    overflow_d = drop | (overflow_q & ~err_clr);
    skew_err_d = skew_set | (skew_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      p_q         <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      skew_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      skew_err_q  <= skew_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign skew_err  = skew_err_q;

`ifdef LEDR_RX_ACK_EN
  // Ack follows the flipped phase once the token lands in the FIFO
  logic ack_q, ack_d;
  assign ack_d = wr_en ? p_q : ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= ack_d;
  end

  assign ledr_ack = ack_q;
`endif

endmodule
